// File: rtl/cache_line_store.sv
// Direct-mapped cache tag/data store: 16-byte lines of eight 16-bit words, write-through and
// write-allocate, with a miss handshake toward the line-fill FSM.
module cache_line_store #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        hit,
    output logic        stall,
    output logic        miss_detected,
    output logic [15:0] miss_address,
    input  logic        fsm_busy,
    input  logic        fill_data_we,
    input  logic        fill_tag_we,
    input  logic [15:0] fill_addr,
    input  logic [15:0] fill_data,
    output logic        mem_write,
    output logic [15:0] mem_write_addr,
    output logic [15:0] mem_write_data
);

    localparam int unsigned Sets = 1 << INDEX_BITS;
    localparam int unsigned TagW = 12 - INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StMiss, StDone} state_e;

    state_e                  state_q, state_d;
    logic [Sets-1:0]         valid_q;
    logic [TagW-1:0]         tag_q  [Sets];
    logic [15:0]             data_q [Sets][8];

    logic [15:0]             lat_addr_q, lat_wdata_q;
    logic                    lat_we_q, lat_load;

    logic [INDEX_BITS-1:0]   cur_idx, lat_idx, data_idx;
    logic [TagW-1:0]         cur_tag, lat_tag;
    logic [2:0]              cur_word, lat_word, data_word;
    logic [15:0]             data_val;
    logic                    data_we, tag_we, hit_raw;

    logic                    unused_bits;
    assign unused_bits = ^{fsm_busy, addr[0], fill_addr[15:4], fill_addr[0], lat_addr_q[0]};

    assign cur_idx  = addr[3+INDEX_BITS:4];
    assign cur_tag  = addr[15:4+INDEX_BITS];
    assign cur_word = addr[3:1];
    assign lat_idx  = lat_addr_q[3+INDEX_BITS:4];
    assign lat_tag  = lat_addr_q[15:4+INDEX_BITS];
    assign lat_word = lat_addr_q[3:1];

    assign hit_raw = req && valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);

    always_comb begin
        state_d        = state_q;
        rdata          = '0;
        hit            = 1'b0;
        stall          = 1'b0;
        miss_detected  = 1'b0;
        miss_address   = '0;
        mem_write      = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        lat_load       = 1'b0;
        data_we        = 1'b0;
        data_idx       = cur_idx;
        data_word      = cur_word;
        data_val       = wdata;
        tag_we         = 1'b0;
        // Outputs are forced low while reset is held, not just after the first edge.
        if (rst_n) begin
            hit   = hit_raw;
            rdata = hit_raw ? data_q[cur_idx][cur_word] : '0;
            unique case (state_q)
                StIdle: begin
                    if (req && !hit_raw) begin
                        stall         = 1'b1;
                        miss_detected = 1'b1;
                        miss_address  = {addr[15:4], 4'h0};
                        lat_load      = 1'b1;
                        state_d       = StMiss;
                    end else if (req && we) begin
                        mem_write      = 1'b1;
                        mem_write_addr = addr;
                        mem_write_data = wdata;
                        data_we        = 1'b1;
                    end
                end
                StMiss: begin
                    stall         = 1'b1;
                    miss_detected = 1'b1;
                    miss_address  = {lat_addr_q[15:4], 4'h0};
                    data_idx      = lat_idx;
                    data_word     = fill_addr[3:1];
                    data_val      = fill_data;
                    data_we       = fill_data_we;
                    if (fill_tag_we) begin
                        tag_we  = 1'b1;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    // The retried access now hits; a latched store completes here.
                    if (req && hit_raw && lat_we_q) begin
                        mem_write      = 1'b1;
                        mem_write_addr = lat_addr_q;
                        mem_write_data = lat_wdata_q;
                        data_we        = 1'b1;
                        data_idx       = lat_idx;
                        data_word      = lat_word;
                        data_val       = lat_wdata_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (lat_load) begin
                lat_addr_q  <= addr;
                lat_wdata_q <= wdata;
                lat_we_q    <= we;
            end
            if (tag_we) begin
                valid_q[lat_idx] <= 1'b1;
            end
        end
    end

    // Tag and data contents are don't-care until their valid bit is set.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[lat_idx] <= lat_tag;
        end
        if (data_we) begin
            data_q[data_idx][data_word] <= data_val;
        end
    end

endmodule

// File: tb/tb_cache_line_store.sv
// Directed bench for cache_line_store: a line-level reference model checks every cycle, and
// hand-computed expectations along the test plan pin the model.
module tb_cache_line_store;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, fsm_busy = 1'b0;
    logic        fill_data_we = 1'b0, fill_tag_we = 1'b0;
    logic [15:0] addr = '0, wdata = '0, fill_addr = '0, fill_data = '0;
    logic [15:0] rdata, miss_address, mem_write_addr, mem_write_data;
    logic        hit, stall, miss_detected, mem_write;

    int n_checks = 0;
    int n_fail   = 0;

    cache_line_store #(.INDEX_BITS(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .hit            (hit),
        .stall          (stall),
        .miss_detected  (miss_detected),
        .miss_address   (miss_address),
        .fsm_busy       (fsm_busy),
        .fill_data_we   (fill_data_we),
        .fill_tag_we    (fill_tag_we),
        .fill_addr      (fill_addr),
        .fill_data      (fill_data),
        .mem_write      (mem_write),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a line is (valid, tag, 8 words); a miss is a pending request.
    bit          m_valid [64];
    int          m_tag   [64];
    logic [15:0] m_data  [64][8];
    bit          m_wait, m_just, m_lwe;
    logic [15:0] m_laddr, m_lwdata;

    function automatic int set_of(input logic [15:0] a);
        return int'(a >> 4) % 64;
    endfunction
    function automatic int word_of(input logic [15:0] a);
        return int'(a >> 1) % 8;
    endfunction
    function automatic int tag_of(input logic [15:0] a);
        return int'(a >> 10);
    endfunction

    initial begin
        for (int s = 0; s < 64; s++) begin
            m_valid[s] = 1'b0;
            m_tag[s]   = 0;
            for (int w = 0; w < 8; w++) m_data[s][w] = '0;
        end
        m_wait = 1'b0;
        m_just = 1'b0;
    end

    always @(negedge clk) begin : compare
        bit          h, e_stall, e_md, e_mw;
        logic [15:0] e_rd, e_ma, e_mwa, e_mwd;
        int          s;
        e_stall = 1'b0; e_md = 1'b0; e_mw = 1'b0; h = 1'b0;
        e_rd = '0; e_ma = '0; e_mwa = '0; e_mwd = '0;
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
            m_wait = 1'b0;
            m_just = 1'b0;
        end else begin
            s = set_of(addr);
            h = req && m_valid[s] && (m_tag[s] == tag_of(addr));
            if (h) e_rd = m_data[s][word_of(addr)];
            if (m_wait) begin
                e_stall = 1'b1;
                e_md    = 1'b1;
                e_ma    = {m_laddr[15:4], 4'h0};
                if (fill_data_we) m_data[set_of(m_laddr)][word_of(fill_addr)] = fill_data;
                if (fill_tag_we) begin
                    m_valid[set_of(m_laddr)] = 1'b1;
                    m_tag[set_of(m_laddr)]   = tag_of(m_laddr);
                    m_wait = 1'b0;
                    m_just = 1'b1;
                end
            end else if (m_just) begin
                m_just = 1'b0;
                if (h && m_lwe) begin
                    e_mw  = 1'b1;
                    e_mwa = m_laddr;
                    e_mwd = m_lwdata;
                    m_data[set_of(m_laddr)][word_of(m_laddr)] = m_lwdata;
                end
            end else if (req && !h) begin
                e_stall  = 1'b1;
                e_md     = 1'b1;
                e_ma     = {addr[15:4], 4'h0};
                m_laddr  = addr;
                m_lwe    = we;
                m_lwdata = wdata;
                m_wait   = 1'b1;
            end else if (h && we) begin
                e_mw  = 1'b1;
                e_mwa = addr;
                e_mwd = wdata;
                m_data[s][word_of(addr)] = wdata;
            end
        end
        chk("cmp_hit", {15'b0, hit}, {15'b0, h});
        chk("cmp_rdata", rdata, e_rd);
        chk("cmp_stall", {15'b0, stall}, {15'b0, e_stall});
        chk("cmp_miss_detected", {15'b0, miss_detected}, {15'b0, e_md});
        chk("cmp_mem_write", {15'b0, mem_write}, {15'b0, e_mw});
        if (!rst_n || e_md) chk("cmp_miss_address", miss_address, e_ma);
        if (!rst_n || e_mw) begin
            chk("cmp_mem_write_addr", mem_write_addr, e_mwa);
            chk("cmp_mem_write_data", mem_write_data, e_mwd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_line(input logic [15:0] base, input logic [15:0] d0);
        for (int i = 0; i < 8; i++) begin
            fill_data_we = 1'b1;
            fill_tag_we  = (i == 7);
            fill_addr    = base + 16'(2 * i);
            fill_data    = d0 + 16'(i);
            step();
        end
        fill_data_we = 1'b0;
        fill_tag_we  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: every output low
        step(); step();
        @(negedge clk);
        chk("rst_rdata", rdata, 16'h0);
        chk("rst_hit", {15'b0, hit}, 16'h0);
        chk("rst_stall", {15'b0, stall}, 16'h0);
        chk("rst_miss_detected", {15'b0, miss_detected}, 16'h0);
        chk("rst_miss_address", miss_address, 16'h0);
        chk("rst_mem_write", {15'b0, mem_write}, 16'h0);
        step();
        rst_n = 1'b1;

        // Cold read miss and fill
        req = 1'b1; addr = 16'h0040;
        @(negedge clk);
        chk("miss_hit", {15'b0, hit}, 16'h0);
        chk("miss_md", {15'b0, miss_detected}, 16'h1);
        chk("miss_addr", miss_address, 16'h0040);
        chk("miss_stall", {15'b0, stall}, 16'h1);
        step();
        fill_line(16'h0040, 16'h00A0);
        @(negedge clk);
        chk("done_stall", {15'b0, stall}, 16'h0);
        chk("done_hit", {15'b0, hit}, 16'h1);
        chk("done_rdata", rdata, 16'h00A0);
        chk("done_md", {15'b0, miss_detected}, 16'h0);
        step();
        addr = 16'h004E;
        @(negedge clk);
        chk("hit_last_word", rdata, 16'h00A7);
        chk("hit_last_stall", {15'b0, stall}, 16'h0);
        step();

        // Write hit
        we = 1'b1; addr = 16'h0042; wdata = 16'h1234;
        @(negedge clk);
        chk("wh_mem_write", {15'b0, mem_write}, 16'h1);
        chk("wh_mw_addr", mem_write_addr, 16'h0042);
        chk("wh_mw_data", mem_write_data, 16'h1234);
        chk("wh_stall", {15'b0, stall}, 16'h0);
        step();
        we = 1'b0;
        @(negedge clk);
        chk("wh_readback", rdata, 16'h1234);
        step();

        // Write miss: store completes in the cycle after the fill
        we = 1'b1; addr = 16'h0086; wdata = 16'h5555;
        @(negedge clk);
        chk("wm_stall", {15'b0, stall}, 16'h1);
        chk("wm_miss_addr", miss_address, 16'h0080);
        step();
        fill_line(16'h0080, 16'h00C0);
        @(negedge clk);
        chk("wm_mem_write", {15'b0, mem_write}, 16'h1);
        chk("wm_mw_addr", mem_write_addr, 16'h0086);
        chk("wm_mw_data", mem_write_data, 16'h5555);
        step();
        we = 1'b0;
        @(negedge clk);
        chk("wm_readback", rdata, 16'h5555);
        step();
        addr = 16'h0088;
        @(negedge clk);
        chk("wm_fill_word4", rdata, 16'h00C4);
        step();

        // Conflict miss evicts set 4
        addr = 16'h0440;
        @(negedge clk);
        chk("cm_md", {15'b0, miss_detected}, 16'h1);
        chk("cm_miss_addr", miss_address, 16'h0440);
        step();
        fill_line(16'h0440, 16'h00B0);
        @(negedge clk);
        chk("cm_rdata", rdata, 16'h00B0);
        step();
        addr = 16'h0040;
        @(negedge clk);
        chk("cm_evicted_hit", {15'b0, hit}, 16'h0);
        chk("cm_evicted_md", {15'b0, miss_detected}, 16'h1);
        step();

        // Reset in the middle of a fill
        for (int i = 0; i < 3; i++) begin
            fill_data_we = 1'b1;
            fill_addr    = 16'h0040 + 16'(2 * i);
            fill_data    = 16'h00E0 + 16'(i);
            step();
        end
        fill_data_we = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_stall", {15'b0, stall}, 16'h0);
        chk("mr_md", {15'b0, miss_detected}, 16'h0);
        chk("mr_rdata", rdata, 16'h0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_remiss", {15'b0, miss_detected}, 16'h1);
        step();
        fill_line(16'h0040, 16'h00D0);
        @(negedge clk);
        chk("mr_refill", rdata, 16'h00D0);
        step();

        // Stray fill strobes in IDLE leave the arrays alone
        req = 1'b0;
        fill_data_we = 1'b1; fill_tag_we = 1'b1; fill_addr = 16'h0040; fill_data = 16'hDEAD;
        step(); step();
        fill_data_we = 1'b0; fill_tag_we = 1'b0;
        req = 1'b1; addr = 16'h0040;
        @(negedge clk);
        chk("stray_hit", {15'b0, hit}, 16'h1);
        chk("stray_rdata", rdata, 16'h00D0);
        chk("stray_stall", {15'b0, stall}, 16'h0);
        step();
        req = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
